// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encodings and small opcode-decoding helpers.
package mcycle_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   // All divide/remainder opcodes have bit 2 set.
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // Operand1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
   function automatic logic op1_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Operand2 is treated as signed for MUL, MULH, DIV and REM.
   function automatic logic op2_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mcycle_divstep.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only if it did not go negative.
module mcycle_divstep
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] diff;

   // rem_i < 2*divisor always holds, so the sign of the (WIDTH+1)-bit
   // difference decides the quotient bit and the kept remainder fits WIDTH bits.
   assign diff  = rem_i - {1'b0, div_i};
   assign q_o   = ~diff[WIDTH];
   assign rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];

endmodule

// File: rtl/mcycle_iter.sv
// Iterative multiply/divide unit: shift-add multiply (MUL_STEP bits/cycle)
// and restoring divide (1 bit/cycle) on operand magnitudes, with sign
// correction in a final FIX cycle. Both halves of the result are always written.
module mcycle_iter
   import mcycle_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic             Abort,
   input  logic [2:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(WIDTH / MUL_STEP - 1);
   localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   res1_q, res1_d, res2_q, res2_d;
   // Shared accumulator: multiply {partial product, remaining multiplier};
   // divide {partial remainder, remaining dividend / quotient bits}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
   logic               div_q, div_d;
   logic               neg_lo_q, neg_lo_d;  // negate product / quotient
   logic               neg_hi_q, neg_hi_d;  // negate remainder

   // Conditional two's-complement negation used by the sign-fix step.
   function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   // Start-cycle operand decode: signs, magnitudes and the two special cases.
   logic             s1, s2, div0, ovf;
   logic [WIDTH-1:0] mag1, mag2;
   assign s1   = op1_signed(MCycleOp) & Operand1[WIDTH-1];
   assign s2   = op2_signed(MCycleOp) & Operand2[WIDTH-1];
   assign mag1 = cneg_w(Operand1, s1);
   assign mag2 = cneg_w(Operand2, s2);
   assign div0 = is_div(MCycleOp) && (Operand2 == '0);
   assign ovf  = is_div(MCycleOp) && op2_signed(MCycleOp) &&
                 (Operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (Operand2 == '1);

   // Multiply step: add multiplicand times the low MUL_STEP multiplier bits
   // to the upper half, then shift the whole accumulator right by MUL_STEP.
   logic [WIDTH+MUL_STEP-1:0] pp, msum;
   logic [2*WIDTH-1:0]        mul_next;
   always_comb begin
      pp = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (acc_q[i]) pp = pp + ({{MUL_STEP{1'b0}}, opnd_q} << i);
      end
      msum = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp;
   end
   assign mul_next = {msum, acc_q[WIDTH-1:MUL_STEP]};

   // Divide step: shift the next dividend bit into the partial remainder.
   logic [WIDTH-1:0]   rem_nx;
   logic               qbit;
   logic [2*WIDTH-1:0] div_next;
   mcycle_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem_i (({acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]})),
      .div_i (opnd_q),
      .rem_o (rem_nx),
      .q_o   (qbit)
   );
   assign div_next = {rem_nx, acc_q[WIDTH-2:0], qbit};

   // Next-state logic: Abort wins over everything and leaves results untouched.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      res1_d   = res1_q;
      res2_d   = res2_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (Abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  div_d    = is_div(MCycleOp);
                  cnt_d    = '0;
                  neg_lo_d = s1 ^ s2;
                  neg_hi_d = s1;
                  if (div0) begin
                     // Final values preloaded; FIX passes them through.
                     acc_d    = {Operand1, {WIDTH{1'b1}}};
                     neg_lo_d = 1'b0;
                     neg_hi_d = 1'b0;
                     state_d  = S_FIX;
                  end else if (ovf) begin
                     acc_d    = {{WIDTH{1'b0}}, Operand1};
                     neg_lo_d = 1'b0;
                     neg_hi_d = 1'b0;
                     state_d  = S_FIX;
                  end else if (is_div(MCycleOp)) begin
                     acc_d   = {{WIDTH{1'b0}}, mag1};
                     opnd_d  = mag2;
                     state_d = S_CALC;
                  end else begin
                     acc_d   = {{WIDTH{1'b0}}, mag2};
                     opnd_d  = mag1;
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_d = div_q ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == (div_q ? LAST_DIV : LAST_MUL)) state_d = S_FIX;
            end
            S_FIX: begin
               if (div_q) begin
                  res1_d = cneg_w(acc_q[WIDTH-1:0], neg_lo_q);
                  res2_d = cneg_w(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
               end else begin
                  {res2_d, res1_d} = cneg_2w(acc_q, neg_lo_q);
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Control and visible outputs: asynchronously cleared by RESET.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         res1_q  <= '0;
         res2_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         res1_q  <= res1_d;
         res2_q  <= res2_d;
      end
   end

   // Datapath registers: always reloaded at Start, so no reset needed.
   always_ff @(posedge CLK) begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
   end

   assign Result1 = res1_q;
   assign Result2 = res2_q;
   assign Done    = done_q;
   assign Busy    = ~RESET & ((state_q == S_IDLE) ? (Start & ~Abort) : 1'b1);

endmodule

// File: doc/mcycle_iter.md
MCYCLE_ITER -- requirements
Module: mcycle_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; SHALL be even and >= 8.
REQ-002 Parameter MUL_STEP, default 2: multiplier bits retired per cycle; SHALL be 1, 2 or 4 and divide WIDTH.
REQ-003 Port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port RESET  in  1  asynchronous, active-high reset.
REQ-005 Port Start  in  1  request; sampled only in IDLE.
REQ-006 Port Abort  in  1  pipeline flush; cancels any operation in flight.
REQ-007 Port MCycleOp  in  3  opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port Operand1  in  WIDTH  multiplicand or dividend; rs1.
REQ-009 Port Operand2  in  WIDTH  multiplier or divisor; rs2.
REQ-010 Port Result1  out  WIDTH  product LSW or quotient; registered.
REQ-011 Port Result2  out  WIDTH  product MSW or remainder; registered.
REQ-012 Port Busy  out  1  stall signal to the pipeline.
REQ-013 Port Done  out  1  one-cycle pulse; Result1/Result2 are valid while Done is high.

Function
REQ-014 FSM states: IDLE, CALC, FIX; IDLE after reset.
REQ-015 IDLE with Start=1 and Abort=0: latch opcode, operand signs and absolute values; clear the step counter; go to CALC, or to FIX for special cases (REQ-021, REQ-022).
REQ-016 Signedness per operand:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: Operand1 signed, Operand2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
REQ-017 Multiply in CALC: shift-add on magnitudes, MUL_STEP bits per cycle, 2*WIDTH accumulator; exactly WIDTH/MUL_STEP CALC cycles.
REQ-018 Divide in CALC: restoring, one quotient bit per cycle; exactly WIDTH CALC cycles.
REQ-019 FIX: apply sign correction and register results, then return to IDLE:
  - product negated when signed operand signs differ;
  - quotient negated when signs differ;
  - remainder takes the dividend's sign.
REQ-020 Result1/Result2 are both written for every opcode (full product or quotient/remainder pair); the pipeline selects the half it needs.
REQ-021 Divide by zero: quotient = all ones, remainder = Operand1; skip CALC.
REQ-022 Signed overflow (DIV/REM, Operand1 = most-negative value, Operand2 = -1): quotient = Operand1, remainder = 0; skip CALC.
REQ-023 Busy = 1 combinationally in the Start cycle, and in every CALC and FIX cycle; 0 otherwise.
REQ-024 Done is registered; high for exactly the one cycle after FIX.
REQ-025 Latency, with Start in cycle 0:
  - Done in cycle N+2, where N = WIDTH/MUL_STEP (multiply) or WIDTH (divide);
  - special cases: Done in cycle 2.
REQ-026 Start while not in IDLE SHALL be ignored; operand and opcode changes after the Start cycle SHALL be ignored.
REQ-027 Abort=1 in any state: next state IDLE, no Done, Result1/Result2 unchanged; Abort overrides a simultaneous Start.
REQ-028 Start is honoured in the cycle Done is high, so back-to-back operations are possible.

Reset
REQ-029 RESET SHALL immediately force: state IDLE, Result1 = 0, Result2 = 0, Done = 0, counter = 0.
REQ-030 Reset mid-operation discards the operation; no Done follows.
REQ-031 Busy = 0 while RESET is asserted.

Structure
REQ-032 Shared package mcycle_pkg holds:
  - opcode localparams (OP_MUL..OP_REMU);
  - state encodings;
  - helper is_div = MCycleOp[2].
REQ-033 One sub-module, mcycle_divstep: combinational one-bit restoring step (remainder, divisor in; next remainder, quotient bit out).
REQ-034 No vendor IP; synthesizable for Nexys 4 DDR at 100 MHz.

Verification
REQ-035 MUL, 0xFFFFFFFE x 0x00000003 (WIDTH 32, MUL_STEP 2) -> Done in cycle 18; Result1 = 0xFFFFFFFA, Result2 = 0xFFFFFFFF.
REQ-036 MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> Result2 = 0xFFFFFFFF, Result1 = 0x00000001; MULHU on the same operands -> Result2 = 0xFFFFFFFE.
REQ-037 DIV, -7 / 2 -> Done in cycle 34; Result1 = 0xFFFFFFFD (-3), Result2 = 0xFFFFFFFF (-1).
REQ-038 DIVU, 5 / 0 -> Done in cycle 2; Result1 = 0xFFFFFFFF, Result2 = 5. DIV, 0x80000000 / 0xFFFFFFFF -> Done in cycle 2; Result1 = 0x80000000, Result2 = 0.
REQ-039 Start DIV, Abort in cycle 10, new Start MUL 3x4 in cycle 11 -> no Done for the DIV; MUL Done in cycle 29 with Result1 = 12.
REQ-040 RESET asserted in cycle 5 of a multiply -> outputs 0 immediately, Busy = 0, no Done; a Start after reset release completes normally.
